// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: play states, chart entry layout,
// lane encoding, default start/restart keycodes and a popcount helper.
package note_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        LaneLeft  = 2'd0,
        LaneDown  = 2'd1,
        LaneUp    = 2'd2,
        LaneRight = 2'd3
    } lane_t;

    typedef struct packed {
        logic        endMark;
        logic        rsvd;
        lane_t       lane;
        logic [11:0] frame;
    } chart_entry_t;

    localparam logic [7:0]  KEY_START   = 8'h2C;
    localparam logic [7:0]  KEY_RESTART = 8'h01;
    localparam logic [11:0] FRAME_MAX   = 12'hFFF;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/note_sequencer_slot_allocator.sv
// Dropper slot pool: busy vector, lowest-free-slot priority encoder and full flag.
// Releases are applied before allocation so a slot finishing this cycle can be reused at once.
module slot_allocator #(
    parameter int N_SLOTS = 8
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               i_clear,
    input  logic               i_alloc,
    input  logic [N_SLOTS-1:0] i_release,
    output logic [N_SLOTS-1:0] o_busy,
    output logic [3:0]         o_freeIdx,
    output logic               o_full
);

    logic [N_SLOTS-1:0] r_busy;
    logic [N_SLOTS-1:0] w_held;
    logic [N_SLOTS-1:0] w_setMask;
    logic [3:0]         w_freeIdx;

    assign w_held = r_busy & ~i_release;

    // Scan downwards so the lowest free index wins.
    always_comb begin
        w_freeIdx = 4'd0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!w_held[i]) begin
                w_freeIdx = 4'(i);
            end
        end
    end

    always_comb begin
        w_setMask = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_setMask[i] = i_alloc && (w_freeIdx == 4'(i));
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset || i_clear) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_held | w_setMask;
        end
    end

    assign o_busy    = r_busy;
    assign o_freeIdx = w_freeIdx;
    assign o_full    = &w_held;

endmodule

// File: rtl/note_sequencer.sv
// Song-level sequencer: walks the chart ROM, launches droppers into free slots and scores results.
// Define COMBO_BONUS_EN to score hits double while the running combo is at least 10.
import note_seq_pkg::*;

module note_sequencer #(
    parameter int         N_SLOTS     = 8,
    parameter int         CHART_AW    = 8,
    parameter logic [7:0] START_KEY   = KEY_START,
    parameter logic [7:0] RESTART_KEY = KEY_RESTART
) (
    input  logic                frame_clk,
    input  logic                Reset,
    input  logic [7:0]          keycode,
    output logic [CHART_AW-1:0] chart_addr,
    input  logic [15:0]         chart_data,
    output logic                launch_valid,
    output logic [3:0]          launch_slot,
    output logic [1:0]          launch_lane,
    input  logic [N_SLOTS-1:0]  slot_done,
    input  logic [N_SLOTS-1:0]  slot_hit,
    output logic [N_SLOTS-1:0]  slot_busy,
    output logic [15:0]         score,
    output logic [7:0]          combo,
    output logic [7:0]          misses,
    output logic [1:0]          state
);

    seq_state_t          r_state;
    logic [CHART_AW-1:0] r_chartAddr;
    logic [11:0]         r_frameCnt;
    logic                r_launchValid;
    logic [3:0]          r_launchSlot;
    logic [1:0]          r_launchLane;
    logic [15:0]         r_score;
    logic [7:0]          r_combo;
    logic [7:0]          r_misses;

    chart_entry_t        w_entry;
    logic                w_unusedRsvd;
    logic                w_inPlay;
    logic                w_active;
    logic                w_chartEnd;
    logic                w_noteDue;
    logic                w_doLaunch;
    logic                w_overflow;
    logic [N_SLOTS-1:0]  w_busy;
    logic [N_SLOTS-1:0]  w_resolved;
    logic [N_SLOTS-1:0]  w_busyAfter;
    logic [3:0]          w_freeIdx;
    logic                w_full;
    logic [4:0]          w_hitCnt;
    logic [4:0]          w_missCnt;
    logic                w_anyMiss;
    logic [7:0]          w_comboBase;
    logic [5:0]          w_scoreAdd;
    logic [16:0]         w_scoreSum;
    logic [8:0]          w_comboSum;
    logic [8:0]          w_missSum;

    assign w_entry      = chart_entry_t'(chart_data);
    assign w_unusedRsvd = w_entry.rsvd;

    assign w_inPlay   = (r_state == StPlay);
    assign w_active   = (r_state == StPlay) || (r_state == StDrain);
    assign w_chartEnd = w_entry.endMark || (r_chartAddr == '1);
    assign w_noteDue  = w_inPlay && !w_chartEnd && (w_entry.frame <= r_frameCnt);
    assign w_doLaunch = w_noteDue && !w_full;
    assign w_overflow = w_noteDue && w_full;

    // Done pulses from idle slots are stale and must not score.
    assign w_resolved  = w_active ? (slot_done & w_busy) : '0;
    assign w_busyAfter = w_busy & ~w_resolved;

    slot_allocator #(
        .N_SLOTS (N_SLOTS)
    ) u_alloc (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .i_clear   (r_state == StIdle),
        .i_alloc   (w_doLaunch),
        .i_release (w_resolved),
        .o_busy    (w_busy),
        .o_freeIdx (w_freeIdx),
        .o_full    (w_full)
    );

    assign w_hitCnt    = popcount16(16'(w_resolved & slot_hit));
    assign w_missCnt   = popcount16(16'(w_resolved & ~slot_hit));
    assign w_anyMiss   = (w_missCnt != 5'd0) || w_overflow;
    assign w_comboBase = w_anyMiss ? 8'd0 : r_combo;

`ifdef COMBO_BONUS_EN
    assign w_scoreAdd = (w_comboBase >= 8'd10) ? {w_hitCnt, 1'b0} : {1'b0, w_hitCnt};
`else
    assign w_scoreAdd = {1'b0, w_hitCnt};
`endif

    assign w_scoreSum = {1'b0, r_score} + 17'(w_scoreAdd);
    assign w_comboSum = {1'b0, w_comboBase} + 9'(w_hitCnt);
    assign w_missSum  = {1'b0, r_misses} + 9'(w_missCnt) + 9'(w_overflow);

    // One chart entry at most per frame; a full pool turns the note into a miss.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state       <= StIdle;
            r_chartAddr   <= '0;
            r_frameCnt    <= 12'd0;
            r_launchValid <= 1'b0;
            r_launchSlot  <= 4'd0;
            r_launchLane  <= LaneLeft;
            r_score       <= 16'd0;
            r_combo       <= 8'd0;
            r_misses      <= 8'd0;
        end else begin
            r_launchValid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_chartAddr <= '0;
                    r_frameCnt  <= 12'd0;
                    r_score     <= 16'd0;
                    r_combo     <= 8'd0;
                    r_misses    <= 8'd0;
                    if (keycode == START_KEY) begin
                        r_state <= StPlay;
                    end
                end
                StPlay: begin
                    if (r_frameCnt != FRAME_MAX) begin
                        r_frameCnt <= r_frameCnt + 12'd1;
                    end
                    if (w_chartEnd) begin
                        r_state <= StDrain;
                    end
                    if (w_noteDue) begin
                        r_chartAddr <= r_chartAddr + 1'b1;
                    end
                    if (w_doLaunch) begin
                        r_launchValid <= 1'b1;
                        r_launchSlot  <= w_freeIdx;
                        r_launchLane  <= w_entry.lane;
                    end
                end
                StDrain: begin
                    if (w_busyAfter == '0) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    if (keycode == RESTART_KEY) begin
                        r_state  <= StIdle;
                        r_score  <= 16'd0;
                        r_combo  <= 8'd0;
                        r_misses <= 8'd0;
                    end
                end
            endcase
            if (w_active) begin
                r_score  <= w_scoreSum[16] ? 16'hFFFF : w_scoreSum[15:0];
                r_combo  <= w_comboSum[8]  ? 8'hFF    : w_comboSum[7:0];
                r_misses <= w_missSum[8]   ? 8'hFF    : w_missSum[7:0];
            end
        end
    end

    assign chart_addr   = r_chartAddr;
    assign launch_valid = r_launchValid;
    assign launch_slot  = r_launchSlot;
    assign launch_lane  = r_launchLane;
    assign slot_busy    = w_busy;
    assign score        = r_score;
    assign combo        = r_combo;
    assign misses       = r_misses;
    assign state        = r_state;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer (4 slots): launches are scoreboarded against a queue
// of expected slot/lane/cycle entries; score, combo, misses and state are checked per step.
module tb_note_sequencer;

    localparam int          NS        = 4;
    localparam logic [7:0]  START     = 8'h2C;
    localparam logic [7:0]  RESTART   = 8'h01;
    localparam logic [15:0] CHART_END = 16'h8000;
    localparam int S_IDLE = 0, S_PLAY = 1, S_DRAIN = 2, S_DONE = 3;
`ifdef COMBO_BONUS_EN
    localparam int SCORE_12_HITS = 14;
`else
    localparam int SCORE_12_HITS = 12;
`endif

    logic          frame_clk = 1'b0;
    logic          Reset     = 1'b1;
    logic [7:0]    keycode   = 8'h00;
    logic [7:0]    chart_addr;
    logic [15:0]   chart_data;
    logic          launch_valid;
    logic [3:0]    launch_slot;
    logic [1:0]    launch_lane;
    logic [NS-1:0] slot_done = '0;
    logic [NS-1:0] slot_hit  = '0;
    logic [NS-1:0] slot_busy;
    logic [15:0]   score;
    logic [7:0]    combo;
    logic [7:0]    misses;
    logic [1:0]    state;

    logic [15:0] chartRom [256];

    typedef struct {
        logic [3:0] slot;
        logic [1:0] lane;
        int         cyc;
    } launch_t;

    launch_t expQ[$];
    launch_t monExp;
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;

    note_sequencer #(
        .N_SLOTS  (NS),
        .CHART_AW (8)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .keycode      (keycode),
        .chart_addr   (chart_addr),
        .chart_data   (chart_data),
        .launch_valid (launch_valid),
        .launch_slot  (launch_slot),
        .launch_lane  (launch_lane),
        .slot_done    (slot_done),
        .slot_hit     (slot_hit),
        .slot_busy    (slot_busy),
        .score        (score),
        .combo        (combo),
        .misses       (misses),
        .state        (state)
    );

    assign chart_data = chartRom[chart_addr];

    always #5 frame_clk = ~frame_clk;

    always @(posedge frame_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Drive inputs for n edges, then return them to their quiet values.
    task automatic applyStimulus(input logic [7:0] key, input logic [NS-1:0] done,
                                 input logic [NS-1:0] hit, input int n);
        keycode   = key;
        slot_done = done;
        slot_hit  = hit;
        repeat (n) tick();
        keycode   = 8'h00;
        slot_done = '0;
        slot_hit  = '0;
    endtask

    task automatic expectLaunch(input logic [3:0] slot, input logic [1:0] lane, input int atCyc);
        launch_t e;
        e.slot = slot;
        e.lane = lane;
        e.cyc  = atCyc;
        expQ.push_back(e);
    endtask

    task automatic clearChart();
        for (int i = 0; i < 256; i++) chartRom[i] = CHART_END;
    endtask

    always @(negedge frame_clk) begin
        if (launch_valid === 1'b1) begin
            checkOutput("launch_expected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                checkOutput("launch_slot", 32'(launch_slot), 32'(monExp.slot));
                checkOutput("launch_lane", 32'(launch_lane), 32'(monExp.lane));
                checkOutput("launch_cycle", cyc, monExp.cyc);
            end
        end
    end

    initial begin
        clearChart();
        $display("[TB] reset");
        repeat (2) tick();
        checkOutput("rst_state", 32'(state), S_IDLE);
        checkOutput("rst_addr", 32'(chart_addr), 0);
        checkOutput("rst_busy", 32'(slot_busy), 0);
        checkOutput("rst_launch_valid", 32'(launch_valid), 0);
        checkOutput("rst_launch_slot", 32'(launch_slot), 0);
        checkOutput("rst_launch_lane", 32'(launch_lane), 0);
        checkOutput("rst_score", 32'(score), 0);
        checkOutput("rst_combo", 32'(combo), 0);
        checkOutput("rst_misses", 32'(misses), 0);
        Reset = 1'b0;
        applyStimulus(8'h00, '0, '0, 2);
        checkOutput("idle_hold", 32'(state), S_IDLE);

        // Two notes sharing frame 5: second launches one frame late.
        $display("[TB] shared-frame notes");
        clearChart();
        chartRom[0] = 16'h0005;
        chartRom[1] = 16'h3005;
        applyStimulus(START, '0, '0, 1);
        base = cyc;
        checkOutput("t1_play", 32'(state), S_PLAY);
        expectLaunch(4'd0, 2'd0, base + 6);
        expectLaunch(4'd1, 2'd3, base + 7);
        applyStimulus(8'h00, '0, '0, 8);
        checkOutput("t1_drain", 32'(state), S_DRAIN);
        checkOutput("t1_addr", 32'(chart_addr), 2);
        checkOutput("t1_busy", 32'(slot_busy), 4'b0011);
        applyStimulus(8'h00, 4'b0011, 4'b0011, 1);
        checkOutput("t1_score", 32'(score), 2);
        checkOutput("t1_combo", 32'(combo), 2);
        checkOutput("t1_done", 32'(state), S_DONE);
        applyStimulus(RESTART, '0, '0, 2);
        checkOutput("t1_restart_state", 32'(state), S_IDLE);
        checkOutput("t1_restart_score", 32'(score), 0);
        checkOutput("t1_queue_empty", 32'(expQ.size()), 0);

        // Five notes at frame 1 into four slots: fifth is discarded as a miss.
        $display("[TB] overflow and mixed results");
        clearChart();
        chartRom[0] = 16'h0001;
        chartRom[1] = 16'h1001;
        chartRom[2] = 16'h2001;
        chartRom[3] = 16'h3001;
        chartRom[4] = 16'h1001;
        applyStimulus(START, '0, '0, 1);
        base = cyc;
        for (int i = 0; i < 4; i++) expectLaunch(4'(i), 2'(i), base + 2 + i);
        applyStimulus(8'h00, '0, '0, 6);
        checkOutput("t2_misses", 32'(misses), 1);
        checkOutput("t2_combo", 32'(combo), 0);
        checkOutput("t2_no_launch", 32'(launch_valid), 0);
        checkOutput("t2_busy", 32'(slot_busy), 4'b1111);
        checkOutput("t2_addr", 32'(chart_addr), 5);
        applyStimulus(8'h00, '0, '0, 1);
        checkOutput("t2_drain", 32'(state), S_DRAIN);
        applyStimulus(8'h00, 4'b0100, 4'b0100, 1);
        checkOutput("t3_score_a", 32'(score), 1);
        checkOutput("t3_combo_a", 32'(combo), 1);
        checkOutput("t3_busy_a", 32'(slot_busy), 4'b1011);
        applyStimulus(8'h00, 4'b0011, 4'b0001, 1);
        checkOutput("t3_score_b", 32'(score), 2);
        checkOutput("t3_combo_b", 32'(combo), 1);
        checkOutput("t3_misses_b", 32'(misses), 2);
        checkOutput("t3_busy_b", 32'(slot_busy), 4'b1000);
        applyStimulus(8'h00, 4'b1100, 4'b1100, 1);
        checkOutput("t3_score_c", 32'(score), 3);
        checkOutput("t3_combo_c", 32'(combo), 2);
        checkOutput("t3_busy_c", 32'(slot_busy), 0);
        checkOutput("t3_done", 32'(state), S_DONE);
        applyStimulus(START, '0, '0, 1);
        checkOutput("t3_start_ignored", 32'(state), S_DONE);
        checkOutput("t3_score_held", 32'(score), 3);
        applyStimulus(RESTART, '0, '0, 2);
        checkOutput("t3_restart_misses", 32'(misses), 0);
        checkOutput("t3_queue_empty", 32'(expQ.size()), 0);

        // Twelve hits, each slot freed in the same cycle the next note reuses it.
        $display("[TB] twelve consecutive hits");
        clearChart();
        for (int i = 0; i < 12; i++) chartRom[i] = 16'((i % 4) * 4096 + i + 1);
        applyStimulus(START, '0, '0, 1);
        base = cyc;
        for (int i = 0; i < 12; i++) expectLaunch(4'd0, 2'(i % 4), base + i + 2);
        applyStimulus(8'h00, '0, '0, 2);
        for (int i = 0; i < 12; i++) applyStimulus(8'h00, 4'b0001, 4'b0001, 1);
        checkOutput("t4_drain", 32'(state), S_DRAIN);
        checkOutput("t4_score", 32'(score), SCORE_12_HITS);
        checkOutput("t4_combo", 32'(combo), 12);
        checkOutput("t4_misses", 32'(misses), 0);
        checkOutput("t4_busy", 32'(slot_busy), 0);
        applyStimulus(8'h00, '0, '0, 1);
        checkOutput("t4_done", 32'(state), S_DONE);
        applyStimulus(RESTART, '0, '0, 2);
        checkOutput("t4_queue_empty", 32'(expQ.size()), 0);

        // Reset in the middle of play with slots 0 and 2 in flight.
        $display("[TB] reset during play");
        clearChart();
        chartRom[0] = 16'h0001;
        chartRom[1] = 16'h1001;
        chartRom[2] = 16'h2001;
        chartRom[3] = 16'h0FA0;
        applyStimulus(START, '0, '0, 1);
        base = cyc;
        for (int i = 0; i < 3; i++) expectLaunch(4'(i), 2'(i), base + 2 + i);
        applyStimulus(8'h00, '0, '0, 4);
        applyStimulus(RESTART, 4'b0010, 4'b0010, 1);
        checkOutput("t5_restart_ignored", 32'(state), S_PLAY);
        checkOutput("t5_busy", 32'(slot_busy), 4'b0101);
        checkOutput("t5_score", 32'(score), 1);
        Reset = 1'b1;
        tick();
        checkOutput("t5_rst_state", 32'(state), S_IDLE);
        checkOutput("t5_rst_busy", 32'(slot_busy), 0);
        checkOutput("t5_rst_launch", 32'(launch_valid), 0);
        checkOutput("t5_rst_addr", 32'(chart_addr), 0);
        checkOutput("t5_rst_score", 32'(score), 0);
        Reset = 1'b0;
        applyStimulus(8'h00, '0, '0, 2);
        checkOutput("t5_queue_empty", 32'(expQ.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Time-sequences the falling-arrow dropper pool for one song.
- Walks a chart ROM of (lane, launch frame) entries and allocates a free dropper slot for each note.
- Issues one launch pulse per frame and collects hit/miss results from the slots.
- Sits between the chart ROM and the dropper instances; drives score/combo to the HUD.

Parameters:
N_SLOTS, 8, number of dropper slots managed (1..16)
CHART_AW, 8, chart ROM address width
START_KEY, 8'h2C, keycode that starts play from Idle
RESTART_KEY, 8'h01, keycode that returns Done to Idle

Ports:
frame_clk  in  1  frame-rate clock
Reset  in  1  synchronous, active-high reset
keycode  in  8  current keyboard keycode
chart_addr  out  CHART_AW  chart ROM address (asynchronous ROM, data valid same cycle)
chart_data  in  16  [15]=end marker, [13:12]=lane, [11:0]=launch frame
launch_valid  out  1  one-cycle launch pulse
launch_slot  out  4  slot index being launched
launch_lane  out  2  lane for launched slot (0=left,1=down,2=up,3=right)
slot_done  in  N_SLOTS  per-slot pulse: arrow resolved (hit or reached bottom)
slot_hit  in  N_SLOTS  per-slot, qualified by slot_done: 1=hit, 0=miss
slot_busy  out  N_SLOTS  slot allocated and in flight
score  out  16  accumulated score, saturates at 16'hFFFF
combo  out  8  consecutive hits, saturates at 255
misses  out  8  miss + overflow count, saturates at 255
state  out  2  0=Idle, 1=Play, 2=Drain, 3=Done

Behaviour:
- Reset: state=Idle; chart_addr=0; frame_cnt=0; slot_busy=0; launch_valid=0; launch_slot=0; launch_lane=0; score=0; combo=0; misses=0.
- Idle:
  - Counters and slot_busy held at 0.
  - keycode==START_KEY -> Play next cycle, with frame_cnt=0 and chart_addr=0.
- Play, every cycle:
  - frame_cnt increments by 1; 12-bit, saturates at 4095.
  - If chart_data[15]=1 -> Drain; no launch.
  - Else if chart_data[11:0] <= frame_cnt, issue the note:
    - Pick the lowest-index slot with slot_busy=0.
    - Assert launch_valid for one cycle with launch_slot/launch_lane; set that slot's busy bit.
    - chart_addr increments.
  - If no slot is free, the note is discarded: chart_addr increments, misses+1, combo cleared, launch_valid stays 0.
  - At most one chart entry consumed per frame. Notes sharing a frame issue on successive frames (catch-up; late by 1 frame each).
  - chart_addr wrap at 2^CHART_AW-1: treat as end marker -> Drain.
- Drain: no launches; wait until slot_busy==0 -> Done.
- Done: results held; keycode==RESTART_KEY -> Idle (clears counters next cycle).
- Result processing, in Play and Drain:
  - For every slot with slot_done=1 in the same cycle: clear its busy bit.
  - Hits (popcount of slot_done & slot_hit) add to score and combo.
  - Any miss in the cycle clears combo, then adds that cycle's hits after the clear; misses increments by the miss popcount.
  - slot_done on a non-busy slot is ignored.
- Same-cycle launch and done on one slot: done clears first, so the slot is eligible for that cycle's allocation and ends busy.
- Reset mid-Play: everything returns to reset values next edge. Droppers are reset by the same Reset.
- START_KEY in Play/Drain/Done and RESTART_KEY in Idle/Play: ignored.

Optional Feature:
COMBO_BONUS_EN
- Defined: each hit adds 2 to score when combo (before the increment) >= 10, else 1.
- Undefined: each hit adds 1.

Decomposition:
- Package note_seq_pkg:
  - state enum (Idle/Play/Drain/Done).
  - chart entry struct (end, lane, frame).
  - lane encoding constants.
  - Key constants 8'h2C/8'h01.
- Sub-module slot_allocator: N_SLOTS busy vector, lowest-free priority encoder, set/clear logic, full flag.

Test Plan:
- Chart {lane0@5, lane3@5, END}, START_KEY at cycle 0 -> launch slot0/lane0 at frame 5, slot1/lane3 at frame 6; Drain after addr 2.
- N_SLOTS=2, three notes at frame 1, no slot_done -> launches at frames 1,2; third discarded at frame 3, misses=1, combo=0.
- slot_done=0b11, slot_hit=0b01 in one cycle with combo=4 -> score+1, combo=1, misses+1, slot_busy clears both.
- 12 consecutive hits, COMBO_BONUS_EN defined -> score=14; undefined -> score=12.
- Drain with slot0 busy, slot_done[0] at cycle 20 -> state=Done at cycle 21; RESTART_KEY -> Idle, score=0.
- Reset asserted during Play with slot_busy=0b101 -> next cycle state=Idle, slot_busy=0, launch_valid=0, chart_addr=0.
